// File: rtl/riscv_pkg.sv
// Shared RV32I encoding types: instruction formats, base opcodes and the
// encoder's sequencing states.
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_JAL    = 7'b1101111,
        OP_BRANCH = 7'b1100011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WRITE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle for the instruction encoder.
// master is the loader/memory side, slave is the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_fmt;
    logic [6:0]        req_opcode;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [2:0]        req_funct3;
    logic [6:0]        req_funct7;
    logic [31:0]       req_imm;
    logic              req_last;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;

    modport master (
        output req_valid, req_fmt, req_opcode, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7, req_imm, req_last, mem_ack,
        input  req_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_fmt, req_opcode, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7, req_imm, req_last, mem_ack,
        output req_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_field_pack.sv
// Combinational RV32I field packer: builds the 32-bit word for one request and
// flags illegal format codes and odd branch/jump offsets.
module instr_field_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        misalign
);

    always_comb begin
        word     = '0;
        illegal  = 1'b0;
        misalign = 1'b0;
        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: begin
                // Bit 0 of a branch offset has no slot; it is dropped and reported.
                word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                misalign = imm[0];
            end
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: begin
                word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                misalign = imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I instruction encoder: accepts field-level requests, packs
// them and writes the words to consecutive instruction-memory addresses.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    instr_encoder_if.slave    bus,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [31:0]       pack_word;
    logic              pack_illegal;
    logic              pack_misalign;

    instr_field_pack u_pack (
        .fmt      (bus.req_fmt),
        .opcode   (bus.req_opcode),
        .rd       (bus.req_rd),
        .rs1      (bus.req_rs1),
        .rs2      (bus.req_rs2),
        .funct3   (bus.req_funct3),
        .funct7   (bus.req_funct7),
        .imm      (bus.req_imm),
        .word     (pack_word),
        .illegal  (pack_illegal),
        .misalign (pack_misalign)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            // req_ready is high exactly while in RUN, so req_valid alone is the handshake.
            ST_RUN: begin
                if (bus.req_valid) begin
                    if (pack_illegal) begin
                        err_d = 1'b1;
                        if (bus.req_last) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        wdata_d = pack_word;
                        last_d  = bus.req_last;
                        state_d = ST_WRITE;
                        if (pack_misalign) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (&addr_q) begin
                        err_d = 1'b1;
                    end
                    state_d = last_q ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        req_ready_d = (state_d == ST_RUN);
        mem_we_d    = (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_q      <= 1'b0;
            addr_q      <= BASE;
            wdata_q     <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            err_q       <= err_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign done          = done_q;
    assign err           = err_q;
    assign count         = count_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Sequential RV32I instruction encoder and writer: the inverse of the core's instruction decode path.
- Accepts field-level instruction requests (format, opcode, register indices, funct fields, immediate) over a valid/ready handshake and packs each into a 32-bit word.
- Writes the words to consecutive instruction-memory addresses through an acknowledged write port.
- Sits between the test/boot loader and instruction memory; builds programs for the pipeline without a host-side assembler.

## Interface

Parameters:
- ADDR_W, 10, word-address width of instruction memory.
- BASE_ADDR, 0, word address loaded into the address counter on start.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  begin a program; honoured only in IDLE.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid & req_ready.
- req_fmt  input  3  format code: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 are illegal.
- req_opcode  input  7  opcode field.
- req_rd, req_rs1, req_rs2  input  5 each  register indices.
- req_funct3  input  3  funct3 field.
- req_funct7  input  7  funct7 field (R only).
- req_imm  input  32  immediate, byte offset for B/J.
- req_last  input  1  final instruction of the program.
- mem_we  output  1  write request.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  encoded instruction.
- mem_ack  input  1  write accepted when mem_we & mem_ack.
- done  output  1  one-cycle pulse after the last write or last consumed request.
- err  output  1  sticky error; cleared by start.
- count  output  ADDR_W+1  instructions written since start.

## Operation

- States:
  - IDLE: start -> RUN; load address with BASE_ADDR, clear count and err.
  - RUN: req_ready=1. On handshake with a legal format, register the encoded word -> WRITE.
    - Illegal format (6, 7): set err, write nothing. If req_last -> DONE, else stay in RUN.
  - WRITE: hold mem_we=1 with stable addr/wdata until mem_ack. On ack, address+1 and count+1. If the latched last flag is set -> DONE, else -> RUN.
  - DONE: done=1 for one cycle -> IDLE.
- Field packing:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode. Shift-immediate funct7 bits are supplied by the caller in imm[11:5].
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - Immediate bits outside these ranges are ignored.
- B/J with imm[0]=1: word is still written with bit 0 dropped, and err is set.
- Address wrap: an ack at address 2^ADDR_W-1 wraps the address to 0 and sets err. Writing continues.
- start outside IDLE is ignored. req_valid outside RUN is ignored because req_ready=0.
- Asynchronous reset at any point, including mid-WRITE, aborts immediately. The pending write is lost.

## Timing

- Reset values: state IDLE, req_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, err=0, count=0.
- req_ready is a registered function of state.
- mem_we rises the cycle after the handshake.
- Throughput is 2 cycles per instruction when mem_ack is high on the first mem_we cycle. Each cycle of ack delay adds one cycle.
- count and mem_addr update on the clock edge of the ack.
- done is asserted the cycle after the final ack, or the cycle after an illegal request marked last.
- err is set the cycle after the offending handshake or ack.

## Structure

- Shared package riscv_pkg:
  - format codes FMT_R..FMT_J;
  - opcode constants OP_LUI, OP_JAL, OP_BRANCH, OP_STORE, OP_IMM, OP_REG;
  - FSM state enum.
- Sub-module instr_field_pack: purely combinational fields-to-word packer, plus an illegal-format/misalign flag.
- The top level holds only the FSM, address counter, count, and output registers.

## Test plan

- Start, then R: opcode 0x33, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, last=1, ack tied high -> one write, addr 0, wdata 0x002081B3, done pulse, count=1, err=0.
- Three-instruction program, ack tied high:
  - I: opcode 0x13, rd=5, rs1=0, imm=0xFFFFFFFF -> 0xFFF00293 @0;
  - S: opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423 @1;
  - B: opcode 0x63, funct3=0, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3 @2;
  - then done, count=3.
- mem_ack held low 3 cycles -> mem_we/addr/wdata stable throughout, req_ready=0; write completes on the 4th cycle.
- Request with fmt=6 and last=1 -> no mem_we, err=1, done pulse, count unchanged. The next start clears err.
- ADDR_W=2, BASE_ADDR=0, five U-type requests -> addresses 0,1,2,3,0. err set at the ack of address 3. count=5.
- rst_n low mid-WRITE -> all outputs at reset values immediately. A subsequent start resumes at BASE_ADDR.
